// File: rtl/trace_pkg.sv
// Shared types for the instruction-trace capture buffer.
package trace_pkg;

    localparam int unsigned XLEN_MAX  = 32;
    localparam int unsigned SEQ_W_MAX = 8;
    localparam int unsigned INSTR_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_e;

    // Field widths are the widest supported; narrower instances zero-extend on write.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  pc;
        logic [INSTR_W-1:0]   instr;
        logic [XLEN_MAX-1:0]  result;
        logic                 zero;
        logic [SEQ_W_MAX-1:0] seq;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH-entry trace record array: one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output trace_entry_t rdata
);

    trace_entry_t mem [DEPTH];

    // Record write; contents need no reset because readout is gated by the count.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Instruction-trace capture buffer: optional PC trigger, stop-when-full or circular
// capture, then valid/ready replay of the stored records.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned SEQ_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     cap_valid,
    input  logic [XLEN-1:0]          cap_pc,
    input  logic [31:0]              cap_instr,
    input  logic [XLEN-1:0]          cap_result,
    input  logic                     cap_zero,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [XLEN-1:0]          rd_result,
    output logic                     rd_zero,
    output logic [SEQ_W-1:0]         rd_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    trace_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [SEQ_W-1:0] seq_q;
    logic             overflow_q;

    logic             wr_en_c, pop_c, full_c, trig_hit_c, last_slot_c;
    trace_entry_t     wr_entry, rd_entry;

    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign last_slot_c = (count_q == CNT_W'(DEPTH - 1));
    assign trig_hit_c  = cap_valid && (cap_pc == trig_pc);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, record-write and pop decisions.
    always_comb begin
        state_d = state_q;
        wr_en_c = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
            end
            ARMED: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (!trig_en) begin
                    // Untriggered capture starts immediately, including this cycle's retire.
                    wr_en_c = cap_valid;
                    state_d = CAPTURE;
                end else if (trig_hit_c) begin
                    wr_en_c = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en_c = cap_valid && ((WRAP != 0) || !full_c);
                if (!arm) begin
                    state_d = DONE;
                end else if ((WRAP == 0) && cap_valid && last_slot_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                pop_c = (count_q != '0) && rd_ready;
                if ((count_q == '0) || (pop_c && (count_q == CNT_W'(1)))) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Pointers, occupancy, sequence number and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                seq_q    <= seq_q + SEQ_W'(1);
                if (full_c) begin
                    // Circular mode: the oldest record is overwritten.
                    rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q  <= count_q - CNT_W'(1);
            end
        end
    end

    // Pack the retiring instruction into a record.
    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = XLEN_MAX'(cap_pc);
        wr_entry.instr  = cap_instr;
        wr_entry.result = XLEN_MAX'(cap_result);
        wr_entry.zero   = cap_zero;
        wr_entry.seq    = SEQ_W_MAX'(seq_q);
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_en_c && !clear),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Head record is presented only during readout; fields read zero otherwise.
    assign rd_valid  = (state_q == DONE) && (count_q != '0);
    assign rd_pc     = rd_valid ? XLEN'(rd_entry.pc)     : '0;
    assign rd_instr  = rd_valid ? rd_entry.instr         : '0;
    assign rd_result = rd_valid ? XLEN'(rd_entry.result) : '0;
    assign rd_zero   = rd_valid ? rd_entry.zero          : 1'b0;
    assign rd_seq    = rd_valid ? SEQ_W'(rd_entry.seq)   : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: three DEPTH=4 instances (stop-when-full, circular, 2-bit seq)
// share one stimulus stream and are checked every cycle against a queue-based model.
module tb_trace_buffer;

    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic        zero;
        logic [7:0]  seq;
    } tb_ent_t;

    logic        clock = 1'b0;
    logic        reset, clear, arm, trig_en, cap_valid, cap_zero, rd_ready;
    logic [31:0] trig_pc, cap_pc, cap_instr, cap_result;

    logic        d_valid [NI];
    logic [31:0] d_pc [NI];
    logic [31:0] d_instr [NI];
    logic [31:0] d_result [NI];
    logic        d_zero [NI];
    logic [7:0]  d_seq [NI];
    logic [2:0]  d_count [NI];
    logic        d_ovf [NI];
    logic [1:0]  d_state [NI];

    int checks   = 0;
    int failures = 0;

    // Model: phase per instance (0 idle,1 armed,2 capture,3 done), record queue, seq, overflow.
    int unsigned m_st [NI];
    int unsigned m_seq [NI];
    logic        m_ovf [NI];
    tb_ent_t     mq [NI][$];
    int unsigned seq_mod [NI] = '{256, 256, 4};
    bit          wrap_of [NI] = '{1'b0, 1'b1, 1'b0};

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned SW = (g == 2) ? 2 : 8;
        logic [SW-1:0] seq_w;
        trace_buffer #(
            .XLEN  (32),
            .DEPTH (DEPTH),
            .WRAP  ((g == 1) ? 1 : 0),
            .SEQ_W (SW)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .arm        (arm),
            .trig_en    (trig_en),
            .trig_pc    (trig_pc),
            .cap_valid  (cap_valid),
            .cap_pc     (cap_pc),
            .cap_instr  (cap_instr),
            .cap_result (cap_result),
            .cap_zero   (cap_zero),
            .rd_ready   (rd_ready),
            .rd_valid   (d_valid[g]),
            .rd_pc      (d_pc[g]),
            .rd_instr   (d_instr[g]),
            .rd_result  (d_result[g]),
            .rd_zero    (d_zero[g]),
            .rd_seq     (seq_w),
            .count      (d_count[g]),
            .overflow   (d_ovf[g]),
            .state      (d_state[g])
        );
        assign d_seq[g] = 8'(seq_w);
    end

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=0x%0h expected=0x%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_st[k]  = 0;
            m_seq[k] = 0;
            m_ovf[k] = 1'b0;
            mq[k].delete();
        end
    endtask

    task automatic push(input int k);
        tb_ent_t e;
        e.pc     = cap_pc;
        e.instr  = cap_instr;
        e.result = cap_result;
        e.zero   = cap_zero;
        e.seq    = 8'(m_seq[k] % seq_mod[k]);
        mq[k].push_back(e);
        m_seq[k]++;
    endtask

    task automatic model_step(input int k);
        case (m_st[k])
            0: if (arm) m_st[k] = 1;
            1: begin
                if (!arm) m_st[k] = 0;
                else if (!trig_en || (cap_valid && cap_pc == trig_pc)) begin
                    if (cap_valid) push(k);
                    m_st[k] = 2;
                end
            end
            2: begin
                if (cap_valid) begin
                    if (mq[k].size() == DEPTH) begin
                        if (wrap_of[k]) begin
                            void'(mq[k].pop_front());
                            m_ovf[k] = 1'b1;
                            push(k);
                        end
                    end else begin
                        push(k);
                    end
                end
                if (!arm || (!wrap_of[k] && mq[k].size() == DEPTH)) m_st[k] = 3;
            end
            default: begin
                if (mq[k].size() == 0) m_st[k] = 0;
                else if (rd_ready) begin
                    void'(mq[k].pop_front());
                    if (mq[k].size() == 0) m_st[k] = 0;
                end
            end
        endcase
    endtask

    // Advance the model on the same edges the DUT sees.
    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else if (clear) model_reset();
        else for (int k = 0; k < NI; k++) model_step(k);
    end

    // Compare every output of every instance against the model each cycle.
    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            logic    ev;
            tb_ent_t h;
            ev = (m_st[k] == 3) && (mq[k].size() != 0);
            h  = ev ? mq[k][0] : '0;
            chk("state",    k, 64'(d_state[k]),  64'(m_st[k]));
            chk("count",    k, 64'(d_count[k]),  64'(mq[k].size()));
            chk("overflow", k, 64'(d_ovf[k]),    64'(m_ovf[k]));
            chk("rd_valid", k, 64'(d_valid[k]),  64'(ev));
            chk("rd_pc",    k, 64'(d_pc[k]),     64'(h.pc));
            chk("rd_instr", k, 64'(d_instr[k]),  64'(h.instr));
            chk("rd_result",k, 64'(d_result[k]), 64'(h.result));
            chk("rd_zero",  k, 64'(d_zero[k]),   64'(h.zero));
            chk("rd_seq",   k, 64'(d_seq[k]),    64'(h.seq));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic cap(input logic [31:0] pc);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_instr  = $urandom;
        cap_result = $urandom;
        cap_zero   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_result = '0; cap_zero = 1'b0;
        rd_ready = 1'b0;
        #2 reset = 1'b0;
        tick(); tick();
        chk("lit_reset_state", 0, 64'(d_state[0]), 64'd0);
        chk("lit_reset_count", 0, 64'(d_count[0]), 64'd0);
        reset = 1'b1;

        // Untriggered capture of six retires: stop-when-full keeps the first four,
        // circular keeps the last four.
        arm = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin cap(32'(i * 4)); tick(); end
        cap_valid = 1'b0; arm = 1'b0; tick();
        chk("lit_full_count", 0, 64'(d_count[0]), 64'd4);
        chk("lit_full_state", 0, 64'(d_state[0]), 64'd3);
        chk("lit_wrap_ovf",   1, 64'(d_ovf[1]),   64'd1);
        chk("lit_wrap_count", 1, 64'(d_count[1]), 64'd4);
        chk("lit_nowrap_ovf", 0, 64'(d_ovf[0]),   64'd0);

        // Backpressure holds the head record.
        for (int j = 0; j < 5; j++) begin
            chk("lit_hold_valid", 0, 64'(d_valid[0]), 64'd1);
            chk("lit_hold_pc",    0, 64'(d_pc[0]),    64'h0);
            chk("lit_hold_pc",    1, 64'(d_pc[1]),    64'h8);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_pop_pc",  0, 64'(d_pc[0]),  64'(i * 4));
            chk("lit_pop_seq", 0, 64'(d_seq[0]), 64'(i));
            chk("lit_pop_pc",  1, 64'(d_pc[1]),  64'(8 + i * 4));
            chk("lit_pop_seq", 1, 64'(d_seq[1]), 64'(2 + i));
            chk("lit_pop_seq", 2, 64'(d_seq[2]), 64'(i));
            tick();
        end
        rd_ready = 1'b0;
        chk("lit_drained_state", 0, 64'(d_state[0]), 64'd0);
        chk("lit_drained_state", 1, 64'(d_state[1]), 64'd0);
        chk("lit_ovf_kept",      1, 64'(d_ovf[1]),   64'd1);

        // Fifth record: 2-bit sequence wraps back to 0.
        arm = 1'b1; tick();
        cap(32'h40); tick();
        cap_valid = 1'b0; arm = 1'b0; tick();
        chk("lit_seq_wrap", 2, 64'(d_seq[2]), 64'd0);
        chk("lit_seq_cont", 0, 64'(d_seq[0]), 64'd4);
        chk("lit_pc40",     0, 64'(d_pc[0]),  64'h40);

        // Clear beats a simultaneous retire, pop and arm.
        clear = 1'b1; cap(32'h44); rd_ready = 1'b1; arm = 1'b1; tick();
        clear = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0; arm = 1'b0;
        chk("lit_clear_count", 0, 64'(d_count[0]), 64'd0);
        chk("lit_clear_state", 0, 64'(d_state[0]), 64'd0);
        chk("lit_clear_ovf",   1, 64'(d_ovf[1]),   64'd0);
        tick();

        // PC trigger: records start at 0x10.
        trig_en = 1'b1; trig_pc = 32'h10; arm = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin cap(32'(i * 4)); tick(); end
        cap_valid = 1'b0; arm = 1'b0; tick();
        chk("lit_trig_pc",    0, 64'(d_pc[0]),    64'h10);
        chk("lit_trig_seq",   0, 64'(d_seq[0]),   64'd0);
        chk("lit_trig_count", 0, 64'(d_count[0]), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_ready = 1'b0; trig_en = 1'b0;

        // Asynchronous reset in the middle of a capture.
        arm = 1'b1; tick();
        cap(32'h80); tick();
        cap(32'h84); tick();
        cap_valid = 1'b0;
        chk("lit_cap2_count", 0, 64'(d_count[0]), 64'd2);
        chk("lit_cap2_state", 0, 64'(d_state[0]), 64'd2);
        reset = 1'b0; #1;
        chk("lit_rst_state", 0, 64'(d_state[0]), 64'd0);
        chk("lit_rst_count", 0, 64'(d_count[0]), 64'd0);
        chk("lit_rst_valid", 0, 64'(d_valid[0]), 64'd0);
        arm = 1'b0; tick();
        reset = 1'b1; tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 6) cap(32'($urandom_range(0, 7) * 4));
            else cap_valid = 1'b0;
            rd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) arm = ~arm;
            if (!arm && $urandom_range(0, 3) == 0) begin
                trig_en = 1'($urandom_range(0, 1));
                trig_pc = 32'($urandom_range(0, 7) * 4);
            end
            clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0; tick(); reset = 1'b1;
            end
            tick();
        end
        clear = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
